hc112_drv: RTL and testbench



---
 rtl/hc112_drv_if.sv | 17 +
 rtl/hc112_drv.sv | 110 +++++++++++
 tb/tb_hc112_drv.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hc112_drv_if.sv
// hc112_drv_if: CPU request/ack bus plus the JK excitation and Q feedback lines of the hc112 bank.
interface hc112_drv_if #(parameter int WIDTH = 2);
    logic             REQ;
    logic [1:0]       OP;
    logic [WIDTH-1:0] TGT;
    logic [WIDTH-1:0] QFB;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             FCP;
    logic             FRDN;
    logic             FSDN;
    logic             BUSY;
    logic             ACK;
    logic             ERR;
    modport master (output REQ, OP, TGT, QFB, input J, K, FCP, FRDN, FSDN, BUSY, ACK, ERR);
    modport slave  (input REQ, OP, TGT, QFB, output J, K, FCP, FRDN, FSDN, BUSY, ACK, ERR);
endinterface

// File: rtl/hc112_drv.sv
// hc112_drv: drives a bank of JK flip-flops to a target with strobe, read-back and retry.
// Define HC112_TOGGLE_EN to excite mismatched bits with J=K=1 instead of directed set/reset.
module hc112_drv #(
    parameter int WIDTH     = 2,
    parameter int WAIT_CYC  = 1,
    parameter int MAX_RETRY = 2
) (
    input logic CPN,
    input logic RDN,
    hc112_drv_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_SETTLE, S_CHECK, S_DONE, S_FAIL} state_t;
    localparam logic [3:0] W_END = 4'(WAIT_CYC - 1);
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);
    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_tgt;
    logic [3:0]       r_wait;
    logic [2:0]       r_retry;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_tgt, w_j, w_k;
    // In IDLE the excitation is computed from the incoming request so it is ready on entry to SETUP.
    always_comb begin
        w_op  = (r_state == S_IDLE) ? ((bus.OP == 2'b11) ? 2'b00 : bus.OP) : r_op;
        w_tgt = (r_state == S_IDLE) ? ((w_op == 2'b01) ? '0 : (w_op == 2'b10) ? '1 : bus.TGT) : r_tgt;
`ifdef HC112_TOGGLE_EN
        w_j   = (w_op == 2'b00) ? (w_tgt ^ bus.QFB) : '0;
        w_k   = w_j;
`else
        w_j   = (w_op == 2'b00) ? (w_tgt & ~bus.QFB) : '0;
        w_k   = (w_op == 2'b00) ? (~w_tgt & bus.QFB) : '0;
`endif
    end
    always_ff @(posedge CPN) begin
        if (!RDN) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_tgt    <= '0;
            r_wait   <= '0;
            r_retry  <= '0;
            bus.J    <= '0;
            bus.K    <= '0;
            bus.FCP  <= 1'b0;
            bus.FRDN <= 1'b1;
            bus.FSDN <= 1'b1;
            bus.BUSY <= 1'b0;
            bus.ACK  <= 1'b0;
            bus.ERR  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.REQ) begin
                    r_op     <= w_op;
                    r_tgt    <= w_tgt;
                    r_wait   <= '0;
                    r_retry  <= '0;
                    bus.ERR  <= 1'b0;
                    bus.BUSY <= 1'b1;
                    bus.J    <= w_j;
                    bus.K    <= w_k;
                    bus.FRDN <= (w_op != 2'b01);
                    bus.FSDN <= (w_op != 2'b10);
                    r_state  <= S_SETUP;
                end
                S_SETUP: if (r_wait == W_END) begin
                    r_wait  <= '0;
                    bus.FCP <= 1'b1;
                    r_state <= S_PULSE;
                end else begin
                    r_wait <= r_wait + 4'd1;
                    bus.J  <= w_j;
                    bus.K  <= w_k;
                end
                S_PULSE: begin
                    bus.FCP  <= 1'b0;
                    bus.J    <= '0;
                    bus.K    <= '0;
                    bus.FRDN <= 1'b1;
                    bus.FSDN <= 1'b1;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: if (r_wait == W_END) begin
                    r_wait  <= '0;
                    r_state <= S_CHECK;
                end else begin
                    r_wait <= r_wait + 4'd1;
                end
                S_CHECK: if (bus.QFB == r_tgt) begin
                    bus.ACK <= 1'b1;
                    r_state <= S_DONE;
                end else if (r_retry < MAX_R) begin
                    r_retry  <= r_retry + 3'd1;
                    bus.J    <= w_j;
                    bus.K    <= w_k;
                    bus.FRDN <= (r_op != 2'b01);
                    bus.FSDN <= (r_op != 2'b10);
                    r_state  <= S_SETUP;
                end else begin
                    bus.ERR <= 1'b1;
                    bus.ACK <= 1'b1;
                    r_state <= S_FAIL;
                end
                default: begin
                    bus.ACK  <= 1'b0;
                    bus.BUSY <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hc112_drv.sv
// tb_hc112_drv: randomized requests against a JK flip-flop bank model and a latency/retry reference.
module tb_hc112_drv;
    localparam int W   = 2;
    localparam int WC  = 1;
    localparam int MR  = 2;
    localparam int LAT = 2 * WC + 2;
    logic CPN = 1'b0;
    logic RDN = 1'b0;
    int n_run = 0;
    int n_fail = 0;
    hc112_drv_if #(.WIDTH(W)) bus();
    hc112_drv #(.WIDTH(W), .WAIT_CYC(WC), .MAX_RETRY(MR)) dut (.CPN(CPN), .RDN(RDN), .bus(bus));
    always #5 CPN = ~CPN;
    // Flip-flop bank: acts on FCP rise; r_skip drops strobes to emulate a flaky bank.
    logic [W-1:0] r_q = '0;
    logic [W-1:0] r_pre = '0;
    logic [W-1:0] r_stuck_val = '0;
    logic         r_stuck = 1'b0;
    int           r_skip = 0;
    assign bus.QFB = r_stuck ? r_stuck_val : r_q;
    always @(posedge bus.FCP) begin
        r_pre = bus.QFB;
        if (r_skip > 0) r_skip--;
        else if (!bus.FRDN) r_q = '0;
        else if (!bus.FSDN) r_q = '1;
        else for (int i = 0; i < W; i++)
            r_q[i] = (bus.J[i] && bus.K[i]) ? ~r_q[i] : bus.J[i] ? 1'b1 : bus.K[i] ? 1'b0 : r_q[i];
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic check_exc(input logic [1:0] op, input logic [W-1:0] t);
        logic [W-1:0] ej, ek;
        for (int i = 0; i < W; i++) begin
            ej[i] = 1'b0;
            ek[i] = 1'b0;
            if ((op == 2'b00 || op == 2'b11) && r_pre[i] != t[i]) begin
`ifdef HC112_TOGGLE_EN
                ej[i] = 1'b1;
                ek[i] = 1'b1;
`else
                if (t[i]) ej[i] = 1'b1;
                else ek[i] = 1'b1;
`endif
            end
        end
        chk("exc", {bus.J, bus.K, bus.FRDN, bus.FSDN}, {ej, ek, op != 2'b01, op != 2'b10});
    endtask
    task automatic do_req(input logic [1:0] op, input logic [W-1:0] tgt, input int skip);
        logic [W-1:0] t, q0;
        int exp_n, n, p;
        logic exp_err, got_ack;
        t = (op == 2'b01) ? '0 : (op == 2'b10) ? '1 : tgt;
        q0 = bus.QFB;
        exp_err = (q0 != t) && (r_stuck || skip > MR);
        exp_n = (q0 == t) ? 1 : exp_err ? MR + 1 : skip + 1;
        @(negedge CPN);
        bus.REQ = 1'b1;
        bus.OP = op;
        bus.TGT = tgt;
        r_skip = skip;
        @(posedge CPN);
        #1;
        bus.REQ = 1'b0;
        chk("busy_acc", bus.BUSY, 1);
        chk("err_clr", bus.ERR, 0);
        n = 0;
        p = 0;
        got_ack = 1'b0;
        while (!got_ack && n < 200) begin
            @(posedge CPN);
            #1;
            n++;
            if (bus.FCP) begin
                p++;
                check_exc(op, t);
            end
            got_ack = bus.ACK;
        end
        chk("ack_edge", n, exp_n * LAT);
        chk("pulses", p, exp_n);
        chk("err", bus.ERR, exp_err);
        chk("busy_ack", bus.BUSY, 1);
        if (!exp_err) chk("q_final", bus.QFB, t);
        @(posedge CPN);
        #1;
        chk("ack_1cyc", bus.ACK, 0);
        chk("idle", bus.BUSY, 0);
        chk("err_sticky", bus.ERR, exp_err);
        r_skip = 0;
    endtask
    initial begin
        int n, p;
        bus.REQ = 1'b0;
        bus.OP = 2'b00;
        bus.TGT = '0;
        repeat (2) @(posedge CPN);
        #1;
        chk("rst", {bus.J, bus.K, bus.FCP, bus.FRDN, bus.FSDN, bus.BUSY, bus.ACK, bus.ERR}, {4'b0000, 6'b011000});
        RDN = 1'b1;
        do_req(2'b00, 2'b01, 0);
        do_req(2'b00, 2'b10, 0);
        do_req(2'b10, 2'b00, 0);
        do_req(2'b01, 2'b10, 0);
        do_req(2'b10, 2'b01, 0);
        do_req(2'b00, 2'b11, 0);
        do_req(2'b11, 2'b01, 0);
        do_req(2'b00, 2'b10, 1);
        r_stuck = 1'b1;
        r_stuck_val = 2'b00;
        do_req(2'b00, 2'b11, 0);
        repeat (3) @(posedge CPN);
        #1;
        chk("err_hold", bus.ERR, 1);
        r_stuck = 1'b0;
        do_req(2'b00, ~bus.QFB, 0);
        // Reset while the strobe is high.
        @(negedge CPN);
        bus.REQ = 1'b1;
        bus.OP = 2'b00;
        bus.TGT = ~bus.QFB;
        n = 0;
        while (!bus.FCP && n < 50) begin
            @(posedge CPN);
            #1;
            bus.REQ = 1'b0;
            n++;
        end
        chk("pulse_seen", bus.FCP, 1);
        RDN = 1'b0;
        @(posedge CPN);
        #1;
        chk("rst_mid", {bus.J, bus.K, bus.FCP, bus.FRDN, bus.FSDN, bus.BUSY, bus.ACK, bus.ERR}, {4'b0000, 6'b011000});
        RDN = 1'b1;
        do_req(2'b00, ~bus.QFB, 0);
        // REQ held high: one strobe per request, next accept right after the ACK cycle.
        @(negedge CPN);
        bus.REQ = 1'b1;
        bus.OP = 2'b00;
        bus.TGT = ~bus.QFB;
        n = 0;
        while (!bus.ACK && n < 50) begin
            @(posedge CPN);
            #1;
            n++;
        end
        chk("hold_ack0", bus.ACK, 1);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            p = 0;
            do begin
                @(posedge CPN);
                #1;
                n++;
                if (bus.FCP) p++;
            end while (!bus.ACK && n < 50);
            chk("hold_gap", n, LAT + 2);
            chk("hold_pulses", p, 1);
        end
        bus.REQ = 1'b0;
        repeat (2) @(posedge CPN);
        #1;
        chk("hold_idle", bus.BUSY, 0);
        for (int r = 0; r < 30; r++)
            do_req(2'($urandom_range(0, 3)), W'($urandom), int'($urandom_range(0, 3)));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
